// File: rtl/udp_frame_arbiter.sv
// Round-robin, frame-atomic arbiter merging several show-ahead FIFO read sides
// into one registered output stream. Malformed frames are dropped; oversize frames are truncated.
module udp_frame_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518,
  localparam int PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W        = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                             rd_clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_dout,
  input  logic [NUM_PORTS-1:0]             in_sof,
  input  logic [NUM_PORTS-1:0]             in_eof,
  output logic [NUM_PORTS-1:0]             in_rd_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic                             out_err,
  output logic [PORT_W-1:0]                out_port,
  output logic                             busy,
  output logic                             err_sof,
  output logic                             err_len
);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t            state;
  logic [PORT_W-1:0] last_grant;
  logic [PORT_W-1:0] grant_nxt;
  logic [PORT_W-1:0] idx;
  logic              req_any;
  logic [CNT_W-1:0]  beat_cnt;

  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_eof;
  logic                  head_empty;
  logic                  load;

  assign head_data  = in_dout[last_grant*DATA_WIDTH +: DATA_WIDTH];
  assign head_eof   = in_eof[last_grant];
  assign head_empty = in_empty[last_grant];
  assign load       = (state == XFER) && !head_empty && (!out_valid || out_ready);
  assign busy       = (state != IDLE);

  // Scan backwards so the port nearest after last_grant is the one left standing.
  always_comb begin
    req_any   = 1'b0;
    grant_nxt = last_grant;
    idx       = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!in_empty[idx]) begin
        req_any   = 1'b1;
        grant_nxt = idx;
      end
    end
  end

  always_comb begin
    in_rd_en = '0;
    if (!reset) begin
      if (load) in_rd_en[last_grant] = 1'b1;
      if (state == DROP && !head_empty) in_rd_en[last_grant] = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      out_port   <= '0;
      err_sof    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      err_sof <= 1'b0;
      err_len <= 1'b0;

      // Output register stage: load a popped beat, or retire the held one.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_sof   <= (beat_cnt == '0);
        out_port  <= last_grant;
        out_eof   <= 1'b0;
        out_err   <= 1'b0;
        beat_cnt  <= beat_cnt + 1'b1;
        if (head_eof) begin
          out_eof <= 1'b1;
          state   <= IDLE;
        end else if (beat_cnt == CNT_W'(MAX_FRAME_LEN - 1)) begin
          out_eof <= 1'b1;
          out_err <= 1'b1;
          err_len <= 1'b1;
          state   <= DROP;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_any) begin
            last_grant <= grant_nxt;
            beat_cnt   <= '0;
            if (in_sof[grant_nxt]) begin
              state <= XFER;
            end else begin
              state   <= DROP;
              err_sof <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!head_empty && head_eof) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/udp_frame_arbiter.md
Name: udp_frame_arbiter

Overview:
- Round-robin, frame-atomic arbiter that merges frames from NUM_PORTS fifo_ctrl read sides into one stream for the UDP parser.
- Runs entirely in the rd_clk domain.
- Pops the granted FIFO a whole frame at a time, delimited by sof/eof.
- Discards malformed frames and truncates oversize frames.

Parameters:
- NUM_PORTS, 2, number of upstream FIFOs (2..8).
- DATA_WIDTH, 8, data word width; matches the fifo_ctrl data width.
- MAX_FRAME_LEN, 1518, maximum beats per frame before truncation.

Ports:
- rd_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_empty  in  NUM_PORTS  per-port fifo_ctrl empty.
- in_dout  in  NUM_PORTS*DATA_WIDTH  per-port head word; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_sof  in  NUM_PORTS  per-port head-word start-of-frame flag.
- in_eof  in  NUM_PORTS  per-port head-word end-of-frame flag.
- in_rd_en  out  NUM_PORTS  per-port pop; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  beat data.
- out_sof  out  1  first beat of frame.
- out_eof  out  1  last beat of frame.
- out_err  out  1  beat closes a truncated frame.
- out_port  out  clog2(NUM_PORTS) (min 1)  source port of the beat.
- busy  out  1  state is not IDLE.
- err_sof  out  1  one-cycle pulse: frame discarded for missing sof.
- err_len  out  1  one-cycle pulse: frame truncated.

Behaviour:
- Upstream FIFO interface:
  - FIFOs are show-ahead: in_dout, in_sof and in_eof are valid whenever in_empty=0.
  - Asserting in_rd_en[i] for one cycle pops exactly one word.
  - in_rd_en[i] is never asserted while in_empty[i]=1.
- Reset:
  - state=IDLE, last_grant=NUM_PORTS-1, so port 0 wins first.
  - All outputs 0, beat_cnt=0.
  - A reset mid-frame abandons the frame; no eof is emitted.
- States: IDLE, XFER, DROP.
- IDLE:
  - Scan ports last_grant+1, last_grant+2, ... (wrapping) and grant g = the first port with in_empty=0.
  - Load last_grant=g and beat_cnt=0.
  - If in_sof[g]=1, go to XFER. Otherwise go to DROP and pulse err_sof.
  - No pop occurs in IDLE. With no requests, stay in IDLE.
- Output register:
  - The output is a single registered stage.
  - load = (state==XFER) && !in_empty[g] && (!out_valid || out_ready).
  - load asserts in_rd_en[g] in the same cycle.
  - The next cycle's out_* reflect the popped word, giving 1 cycle of latency from pop to out_valid.
  - While out_valid && !out_ready, all out_* hold stable.
  - When out_ready and no load occurs, out_valid goes to 0.
- XFER, per loaded beat:
  - out_data = in_dout[g].
  - out_sof = (beat_cnt==0).
  - out_port = g.
  - beat_cnt increments.
  - If in_eof[g]=1: out_eof=1, out_err=0, next state IDLE.
  - Else if beat_cnt==MAX_FRAME_LEN-1: out_eof=1, out_err=1, pulse err_len, next state DROP.
  - in_sof=1 on a non-first beat is ignored and passed as data.
  - in_empty[g]=1 mid-frame stalls with no pop; other ports stay blocked (frame-atomic).
- DROP:
  - in_rd_en[g] = !in_empty[g] every cycle; out_* are unaffected.
  - A popped word with in_eof=1 goes to IDLE.
  - A header word that has both sof=0 and eof=1 is consumed in DROP and returns to IDLE.
- Timing:
  - The earliest regrant is the cycle after the returning-to-IDLE cycle, so each frame costs 1 idle arbitration cycle.
  - The output register may still hold the eof beat while IDLE grants the next frame.
- beat_cnt is 11+ bits wide (clog2(MAX_FRAME_LEN+1)) and never wraps, because truncation occurs first.

Test Plan:
- Single frame: port 0 holds 4 words (sof on 0xA0, eof on 0xA3), out_ready=1. Expect out beats A0..A3 on 4 consecutive cycles, out_sof on the first and out_eof on the last, out_port=0, and in_rd_en[0] high for exactly 4 cycles.
- Round robin: ports 0 and 1 each hold two 3-beat frames. Expect output frame order 0,1,0,1 with no interleaving inside a frame.
- Backpressure: toggle out_ready 1,0,0,1 mid-frame. Expect out_data stable while stalled, no pops while out_valid && !out_ready, and no beats lost or duplicated.
- Missing sof: port 1 head is 3 words with sof=0 and eof on the third, followed by a valid 2-beat frame. Expect one err_sof pulse, the 3 words popped with no output, then the 2-beat frame emitted.
- Oversize: MAX_FRAME_LEN=8, 12-word frame. Expect 8 beats out, with the 8th carrying out_eof=1, out_err=1 and an err_len pulse. The remaining 4 words are dropped, and the next frame is emitted normally.
- Reset mid-XFER after 2 beats: expect all outputs 0 the next cycle, state IDLE, and port 0 granted first afterwards.
